tx_frame_scheduler: RTL and testbench

//   Round-robin frame scheduler for the transmitter commutator datapath.

---
 rtl/tx_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tx_frame_scheduler
//  Brief   : Round-robin frame scheduler sequencing header/length/data fields
//            towards the byte serializer; idle frames when nothing is ready.
//  Revision: 1.0  initial release
// ============================================================================
module tx_frame_scheduler #(
    parameter int         N_CH        = 3,
    parameter int         PAYLOAD_LEN = 9,
    parameter logic [3:0] IDLE_CH     = 4'hF
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [N_CH-1:0] input_ready,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [1:0]      sel,
    output logic [3:0]      channel,
    output logic [7:0]      length,
    output logic [N_CH-1:0] read_req,
    output logic            frame_start,
    output logic            frame_end,
    output logic            underrun
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);

    typedef enum logic [1:0] {
        ARB = 2'd0,
        HDR = 2'd1,
        LEN = 2'd2,
        DAT = 2'd3
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] byte_cnt;
    logic [N_CH-1:0]  grant_mask;
    logic             idle_frame;

    logic             found;
    logic [3:0]       grant_ch;
    logic [N_CH-1:0]  grant_oh;
    logic [PTR_W-1:0] next_ptr;
    logic [N_CH-1:0]  rotated;
    int               idx;

    // Scan rr_ptr, rr_ptr+1, ... (mod N_CH); the first ready channel wins.
    always_comb begin
        found    = 1'b0;
        grant_ch = IDLE_CH;
        grant_oh = '0;
        next_ptr = rr_ptr;
        rotated  = '0;
        idx      = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx     = (int'(rr_ptr) + k) % N_CH;
            rotated = input_ready >> idx;
            if (!found && rotated[0]) begin
                found    = 1'b1;
                grant_ch = 4'(idx);
                grant_oh = N_CH'(1) << idx;
                next_ptr = PTR_W'((idx + 1) % N_CH);
            end
        end
    end

    always_comb begin
        case (state)
            HDR:     sel = 2'd0;
            LEN:     sel = 2'd1;
            DAT:     sel = 2'd2;
            default: sel = 2'd3;
        endcase
    end

    assign out_valid = (state != ARB);
    // Zero-latency pop: the strobe rides on the same cycle as the data accept.
    assign read_req  = (state == DAT && out_ready) ? grant_mask : '0;

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= ARB;
            rr_ptr      <= '0;
            byte_cnt    <= '0;
            grant_mask  <= '0;
            idle_frame  <= 1'b1;
            channel     <= IDLE_CH;
            length      <= 8'd0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            underrun    <= 1'b0;
            case (state)
                ARB: begin
                    channel    <= grant_ch;
                    length     <= found ? 8'(PAYLOAD_LEN) : 8'd0;
                    grant_mask <= grant_oh;
                    idle_frame <= !found;
                    if (found)
                        rr_ptr <= next_ptr;
                    state <= HDR;
                end
                HDR: begin
                    if (out_ready) begin
                        frame_start <= 1'b1;
                        state       <= LEN;
                    end
                end
                LEN: begin
                    if (out_ready) begin
                        if (idle_frame) begin
                            frame_end <= 1'b1;
                            state     <= ARB;
                        end else begin
                            byte_cnt <= '0;
                            state    <= DAT;
                        end
                    end
                end
                DAT: begin
                    if (out_ready) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        // Byte still goes out; the source is flagged as having run dry.
                        if ((input_ready & grant_mask) == '0)
                            underrun <= 1'b1;
                        if (byte_cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
                            frame_end <= 1'b1;
                            state     <= ARB;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tx_frame_scheduler
//  Brief   : Randomized scoreboard bench with a frame-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_tx_frame_scheduler;

    localparam int N_CH = 3;
    localparam int PL   = 9;

    logic            clk = 1'b0;
    logic            arst;
    logic [N_CH-1:0] input_ready;
    logic            out_ready;
    logic            out_valid;
    logic [1:0]      sel;
    logic [3:0]      channel;
    logic [7:0]      length;
    logic [N_CH-1:0] read_req;
    logic            frame_start;
    logic            frame_end;
    logic            underrun;

    tx_frame_scheduler #(.N_CH(N_CH), .PAYLOAD_LEN(PL), .IDLE_CH(4'hF)) dut (
        .clk(clk), .arst(arst), .input_ready(input_ready), .out_ready(out_ready),
        .out_valid(out_valid), .sel(sel), .channel(channel), .length(length),
        .read_req(read_req), .frame_start(frame_start), .frame_end(frame_end),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      sel;
        logic [3:0]      ch;
        logic [7:0]      len;
        logic [N_CH-1:0] rd;
        logic            last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_rr   = 0;
    int   m_rem  = 0;
    int   frames_data = 0;
    int   frames_idle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is one arbitration cycle followed by a list of
    // bytes; the grant is the first ready channel at or after the pointer.
    task automatic model_step();
        int              g;
        int              i;
        logic [N_CH-1:0] tmp;
        exp_t            e;
        if (arst) begin
            q.delete();
            m_rr  = 0;
            m_rem = 0;
        end else if (m_rem == 0) begin
            g = -1;
            for (int k = 0; k < N_CH; k++) begin
                i   = (m_rr + k) % N_CH;
                tmp = input_ready >> i;
                if (g < 0 && tmp[0]) g = i;
            end
            if (g < 0) begin
                e = '{sel: 2'd0, ch: 4'hF, len: 8'd0, rd: '0, last: 1'b0};
                q.push_back(e);
                e = '{sel: 2'd1, ch: 4'hF, len: 8'd0, rd: '0, last: 1'b1};
                q.push_back(e);
                m_rem = 2;
                frames_idle++;
            end else begin
                e = '{sel: 2'd0, ch: 4'(g), len: 8'(PL), rd: '0, last: 1'b0};
                q.push_back(e);
                e.sel = 2'd1;
                q.push_back(e);
                for (int j = 0; j < PL; j++) begin
                    e = '{sel: 2'd2, ch: 4'(g), len: 8'(PL), rd: N_CH'(1) << g, last: (j == PL - 1)};
                    q.push_back(e);
                end
                m_rr  = (g + 1) % N_CH;
                m_rem = PL + 2;
                frames_data++;
            end
        end else if (out_ready) begin
            m_rem--;
        end
    endtask

    // Stimulus: directed phases (idle, single channel, all ready) then random.
    initial begin
        int  streak;
        bit  did_reset;
        arst        = 1'b1;
        input_ready = '0;
        out_ready   = 1'b0;
        streak      = 0;
        did_reset   = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            arst = 1'b0;
            if (cyc < 60) begin
                input_ready = 3'b000; out_ready = 1'b1;
            end else if (cyc < 160) begin
                input_ready = 3'b010; out_ready = 1'b1;
            end else if (cyc < 300) begin
                input_ready = 3'b111; out_ready = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) input_ready = N_CH'($urandom);
                if (streak > 0) begin
                    out_ready = 1'b0;
                    streak--;
                end else if ($urandom_range(0, 40) == 0) begin
                    out_ready = 1'b0;
                    streak    = 4;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                // Abort a data frame after five data bytes have gone out.
                if (cyc >= 1000 && !did_reset && m_rem == PL - 5) begin
                    arst      = 1'b1;
                    did_reset = 1'b1;
                end
            end
            model_step();
            @(posedge clk);
            #1;
        end
        arst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_was_exercised", 32'(did_reset), 32'd1);
        check("idle_frames_seen", 32'(frames_idle > 10), 32'd1);
        check("data_frames_seen", 32'(frames_data > 20), 32'd1);
        check("leftover_bytes_bounded", 32'(q.size() <= PL + 2), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: compares presented fields against the queue head, pops on accept.
    initial begin
        logic            exp_start;
        logic            exp_end;
        logic            exp_unr;
        bit              after_rst;
        int              arb_run;
        logic [N_CH-1:0] tmp;
        exp_t            e;
        exp_start = 1'b0; exp_end = 1'b0; exp_unr = 1'b0;
        after_rst = 1'b0; arb_run = 0;
        forever begin
            @(negedge clk);
            if (arst) begin
                after_rst = 1'b1;
                exp_start = 1'b0; exp_end = 1'b0; exp_unr = 1'b0;
                arb_run   = 0;
                continue;
            end
            check("frame_start", 32'(frame_start), 32'(exp_start));
            check("frame_end",   32'(frame_end),   32'(exp_end));
            check("underrun",    32'(underrun),    32'(exp_unr));
            exp_start = 1'b0; exp_end = 1'b0; exp_unr = 1'b0;
            if (after_rst) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_sel",       32'(sel),       32'd3);
                check("rst_channel",   32'(channel),   32'hF);
                check("rst_read_req",  32'(read_req),  32'd0);
                after_rst = 1'b0;
            end
            if (!out_valid) begin
                check("arb_sel",      32'(sel),      32'd3);
                check("arb_read_req", 32'(read_req), 32'd0);
                arb_run++;
                if (arb_run > 1) check("arb_single_cycle", 32'(arb_run), 32'd1);
            end else if (q.size() == 0) begin
                arb_run = 0;
                check("scoreboard_has_entry", 32'd0, 32'd1);
            end else begin
                arb_run = 0;
                e = q[0];
                check("sel",     32'(sel),     32'(e.sel));
                check("channel", 32'(channel), 32'(e.ch));
                check("length",  32'(length),  32'(e.len));
                if (!out_ready) begin
                    check("stall_read_req", 32'(read_req), 32'd0);
                end else begin
                    void'(q.pop_front());
                    check("read_req", 32'(read_req), 32'(e.rd));
                    tmp       = input_ready >> e.ch;
                    exp_start = (e.sel == 2'd0);
                    exp_end   = e.last;
                    exp_unr   = (e.sel == 2'd2) && !tmp[0];
                end
            end
        end
    end

endmodule
`default_nettype wire
